// File: rtl/costas_loop_pipe_if.sv
// rtl/costas_loop_pipe_if.sv - AXI-Stream style sample channel shared by Costas loop ports
interface costas_loop_pipe_if #(
    parameter int DATA_W = 32
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic              tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/costas_loop_pipe.sv
// rtl/costas_loop_pipe.sv - pipelined BPSK/QPSK Costas carrier-recovery loop on IQ samples
module costas_loop_pipe #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int PHASE_W                = 24,
    parameter int LUT_AW                 = 10,
    parameter int ALPHA_SHIFT            = 6,
    parameter int BETA_SHIFT             = 12,
    parameter int LOCK_THRESH            = 2048,
    parameter int LOCK_CNT               = 256
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_aresetn,
    costas_loop_pipe_if.slave         s00_axis,
    costas_loop_pipe_if.master        m00_axis,
    input  logic                      qpsk_mode,
    output logic signed [PHASE_W-1:0] freq_o,
    output logic                      lock_o
);
    localparam int SW     = C_S00_AXIS_TDATA_WIDTH / 2;
    localparam int LUT_N  = 1 << LUT_AW;
    localparam int CNT_W  = $clog2(LOCK_CNT + 1);
    localparam real TWO_PI = 6.283185307179586;
    localparam logic signed [PHASE_W:0] F_MAX = (PHASE_W+1)'(2 ** (PHASE_W - 2));
    localparam logic signed [PHASE_W:0] F_MIN = -F_MAX;
    localparam logic [CNT_W-1:0] LOCK_CNT_V = CNT_W'(LOCK_CNT);

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) return 16'sh7FFF;
        if (v < -33'sd32768) return 16'sh8000;
        return v[15:0];
    endfunction

    // Quarter-free full-turn tables, rounded to nearest, peak 32767
    logic signed [15:0] cos_tab [LUT_N];
    logic signed [15:0] sin_tab [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam real ANG = TWO_PI * g / LUT_N;
        localparam real CR  = 32767.0 * $cos(ANG);
        localparam real SR  = 32767.0 * $sin(ANG);
        localparam int  CI  = $rtoi(CR >= 0.0 ? CR + 0.5 : CR - 0.5);
        localparam int  SI  = $rtoi(SR >= 0.0 ? SR + 0.5 : SR - 0.5);
        assign cos_tab[g] = 16'(CI);
        assign sin_tab[g] = 16'(SI);
    end

    logic en;
    logic unused_tstrb;
    logic signed [15:0] in_i, in_q;
    logic [PHASE_W-1:0] phase;
    logic signed [PHASE_W-1:0] freq;
    logic [LUT_AW-1:0] lut_addr;
    logic [CNT_W-1:0] lock_cnt;

    assign en              = !(m00_axis.tvalid && !m00_axis.tready);
    assign s00_axis.tready = en;
    assign unused_tstrb    = ^s00_axis.tstrb;
    assign in_i            = s00_axis.tdata[SW-1:0];
    assign in_q            = s00_axis.tdata[2*SW-1:SW];
    assign lut_addr        = phase[PHASE_W-1 -: LUT_AW];
    assign m00_axis.tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){m00_axis.tvalid}};
    assign freq_o          = freq;
    assign lock_o          = (lock_cnt == LOCK_CNT_V);

    logic               s1_v, s1_last;
    logic signed [15:0] s1_i, s1_q, s1_cos, s1_sin;
    logic               s2_v, s2_last;
    logic signed [31:0] s2_ic, s2_qs, s2_qc, s2_is;
    logic               s3_v, s3_last;
    logic signed [15:0] s3_i, s3_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s1_v   <= 1'b0;
            s1_last <= 1'b0;
            s1_i   <= '0;
            s1_q   <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
            s2_v   <= 1'b0;
            s2_last <= 1'b0;
            s2_ic  <= '0;
            s2_qs  <= '0;
            s2_qc  <= '0;
            s2_is  <= '0;
        end else if (en) begin
            s1_v    <= s00_axis.tvalid;
            s1_last <= s00_axis.tlast;
            s1_i    <= in_i;
            s1_q    <= in_q;
            s1_cos  <= cos_tab[lut_addr];
            s1_sin  <= sin_tab[lut_addr];
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_ic   <= 32'(s1_i) * 32'(s1_cos);
            s2_qs   <= 32'(s1_q) * 32'(s1_sin);
            s2_qc   <= 32'(s1_q) * 32'(s1_cos);
            s2_is   <= 32'(s1_i) * 32'(s1_sin);
        end
    end

    // Derotation and phase detector are evaluated on the edge a sample enters S3
    logic signed [15:0] d_i, d_q, err, err_bpsk, err_qpsk;
    logic signed [31:0] bpsk_prod;
    logic signed [32:0] qpsk_raw;
    logic [16:0]        err_abs;
    logic               quiet;

    always_comb begin
        d_i       = sat16((33'(s2_ic) + 33'(s2_qs)) >>> 15);
        d_q       = sat16((33'(s2_qc) - 33'(s2_is)) >>> 15);
        bpsk_prod = 32'(d_i) * 32'(d_q);
        err_bpsk  = sat16(33'(bpsk_prod) >>> 15);
        qpsk_raw  = (d_i[15] ? -33'(d_q) : 33'(d_q)) - (d_q[15] ? -33'(d_i) : 33'(d_i));
        err_qpsk  = sat16(qpsk_raw);
        err       = qpsk_mode ? err_qpsk : err_bpsk;
        err_abs   = err[15] ? (17'd0 - 17'(err)) : 17'(err);
        quiet     = (err_abs < 17'(LOCK_THRESH));
    end

    logic signed [PHASE_W-1:0] e_w, e_beta, e_alpha, freq_new;
    logic signed [PHASE_W:0]   freq_sum;
    logic [PHASE_W-1:0]        phase_next;

    always_comb begin
        e_w      = {err, {(PHASE_W-16){1'b0}}};
        e_beta   = e_w >>> BETA_SHIFT;
        e_alpha  = e_w >>> ALPHA_SHIFT;
        freq_sum = {freq[PHASE_W-1], freq} + {e_beta[PHASE_W-1], e_beta};
        if (freq_sum > F_MAX)      freq_new = F_MAX[PHASE_W-1:0];
        else if (freq_sum < F_MIN) freq_new = F_MIN[PHASE_W-1:0];
        else                       freq_new = freq_sum[PHASE_W-1:0];
        phase_next = phase + freq_new + e_alpha;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s3_v     <= 1'b0;
            s3_last  <= 1'b0;
            s3_i     <= '0;
            s3_q     <= '0;
            phase    <= '0;
            freq     <= '0;
            lock_cnt <= '0;
        end else if (en) begin
            s3_v    <= s2_v;
            s3_last <= s2_last;
            s3_i    <= d_i;
            s3_q    <= d_q;
            if (s2_v) begin
                freq  <= freq_new;
                phase <= phase_next;
                if (!quiet)
                    lock_cnt <= '0;
                else if (lock_cnt != LOCK_CNT_V)
                    lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis.tvalid <= 1'b0;
            m00_axis.tdata  <= '0;
            m00_axis.tlast  <= 1'b0;
        end else if (en) begin
            m00_axis.tvalid <= s3_v;
            m00_axis.tdata  <= C_M00_AXIS_TDATA_WIDTH'({s3_q, s3_i});
            m00_axis.tlast  <= s3_last;
        end
    end
endmodule
